// File: rtl/dirty_flush_ctrl_pkg.sv
// Shared cache types: flush FSM state encoding and per-state output decode.
package dirty_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } flush_state_e;

    function automatic logic state_busy(input flush_state_e st);
        return (st != ST_IDLE) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic state_wb(input flush_state_e st);
        return (st == ST_WB) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic state_done(input flush_state_e st);
        return (st == ST_DONE) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/dirty_flush_ctrl_dirty_bits.sv
// One dirty bit per set with an indexed set port and an indexed clear port;
// a set and a clear to the same index in one cycle leaves the bit set.
module dirty_bit_array #(
    parameter int s_index  = 3,
    parameter int num_sets = 2**s_index
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [s_index-1:0]  set_index,
    input  logic                clr_en,
    input  logic [s_index-1:0]  clr_index,
    output logic [num_sets-1:0] dirty
);

    logic [num_sets-1:0] dirty_r;
    logic [num_sets-1:0] dirty_nxt_s;

    // Next-state of every bit: set has priority over clear.
    always_comb begin
        dirty_nxt_s = dirty_r;
        for (int i = 0; i < num_sets; i++) begin
            if (set_en && (set_index == s_index'(i))) begin
                dirty_nxt_s[i] = 1'b1;
            end else if (clr_en && (clr_index == s_index'(i))) begin
                dirty_nxt_s[i] = 1'b0;
            end else begin
                dirty_nxt_s[i] = dirty_r[i];
            end
        end
    end

    // Bit storage with asynchronous clear-all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_r <= {num_sets{1'b0}};
        end else begin
            dirty_r <= dirty_nxt_s;
        end
    end

    assign dirty = dirty_r;

endmodule

// File: rtl/dirty_flush_ctrl.sv
// Dirty-set tracker with a flush sequencer that scans every set once and
// issues a writeback for each dirty set it finds.
module dirty_flush_ctrl
    import dirty_flush_ctrl_pkg::*;
#(
    parameter int s_index  = 3,
    parameter int num_sets = 2**s_index
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mark_dirty,
    input  logic [s_index-1:0] mark_index,
    input  logic [s_index-1:0] query_index,
    output logic               query_dirty,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               wb_req,
    output logic [s_index-1:0] wb_index,
    input  logic               wb_ack
);

    localparam logic [s_index-1:0] LAST_IDX = s_index'(num_sets - 1);

    flush_state_e        state_r;
    flush_state_e        state_nxt_s;
    logic [s_index-1:0]  ptr_r;
    logic [s_index-1:0]  ptr_nxt_s;
    logic                busy_r;
    logic                wb_req_r;
    logic                flush_done_r;
    logic                clr_en_s;
    logic                ptr_dirty_s;
    logic                ptr_last_s;
    logic [num_sets-1:0] dirty_s;

    dirty_bit_array #(
        .s_index  (s_index),
        .num_sets (num_sets)
    ) u_dirty (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (mark_dirty),
        .set_index (mark_index),
        .clr_en    (clr_en_s),
        .clr_index (ptr_r),
        .dirty     (dirty_s)
    );

    // Read muxes for the external query and the scan pointer.
    always_comb begin
        query_dirty = 1'b0;
        ptr_dirty_s = 1'b0;
        for (int i = 0; i < num_sets; i++) begin
            query_dirty = (query_index == s_index'(i)) ? dirty_s[i] : query_dirty;
            ptr_dirty_s = (ptr_r == s_index'(i)) ? dirty_s[i] : ptr_dirty_s;
        end
    end

    assign ptr_last_s = (ptr_r == LAST_IDX) ? 1'b1 : 1'b0;

    // Flush sequencer next-state; the scan stops at the last set, never wraps.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        clr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nxt_s = ST_SCAN;
                    ptr_nxt_s   = {s_index{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (ptr_dirty_s) begin
                    state_nxt_s = ST_WB;
                end else if (ptr_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                    ptr_nxt_s   = ptr_r + s_index'(1);
                end
            end
            ST_WB: begin
                if (wb_ack) begin
                    clr_en_s = 1'b1;
                    if (ptr_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                        ptr_nxt_s   = ptr_r + s_index'(1);
                    end
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and outputs registered together, decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {s_index{1'b0}};
            busy_r       <= 1'b0;
            wb_req_r     <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            busy_r       <= state_busy(state_nxt_s);
            wb_req_r     <= state_wb(state_nxt_s);
            flush_done_r <= state_done(state_nxt_s);
        end
    end

    assign busy       = busy_r;
    assign wb_req     = wb_req_r;
    assign flush_done = flush_done_r;
    assign wb_index   = ptr_r;

endmodule

// File: tb/tb_dirty_flush_ctrl.sv
// Self-checking bench for dirty_flush_ctrl against a set-level dirty model.
module tb_dirty_flush_ctrl;

    localparam int S = 3;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mark_dirty = 1'b0;
    logic [S-1:0] mark_index = '0;
    logic [S-1:0] query_index = '0;
    logic         query_dirty;
    logic         flush_req = 1'b0;
    logic         busy;
    logic         flush_done;
    logic         wb_req;
    logic [S-1:0] wb_index;
    logic         wb_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    bit model[N];

    dirty_flush_ctrl #(.s_index(S), .num_sets(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mark_dirty  (mark_dirty),
        .mark_index  (mark_index),
        .query_index (query_index),
        .query_dirty (query_dirty),
        .flush_req   (flush_req),
        .busy        (busy),
        .flush_done  (flush_done),
        .wb_req      (wb_req),
        .wb_index    (wb_index),
        .wb_ack      (wb_ack)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        step();
    endtask

    task automatic mark(input int idx);
        mark_dirty = 1'b1;
        mark_index = S'(idx);
        step();
        mark_dirty = 1'b0;
        model[idx] = 1'b1;
    endtask

    // Runs one flush; expected timing: 1 cycle per clean set, 2+delay per dirty set, plus the request cycle.
    task automatic run_flush(input string tag, input int fixed_delay, input int set_on_ack, input int pulse_cyc);
        int exp_q[$];
        int n_dirty, cost, cyc, done_cyc, done_cnt, waited, cur_delay, wb_cnt, cur_idx, idx;
        bit exp_busy;
        for (int i = 0; i < N; i++) if (model[i]) exp_q.push_back(i);
        n_dirty = exp_q.size();
        cost = 0; done_cyc = -1; done_cnt = 0; waited = 0; cur_delay = 0; wb_cnt = 0; cur_idx = -1;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        cyc = 1;
        while (cyc < 300 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            wb_ack = 1'b0;
            mark_dirty = 1'b0;
            flush_req = (cyc == pulse_cyc) ? 1'b1 : 1'b0;
            if (flush_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (wb_req === 1'b1) begin
                if (waited == 0) begin
                    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    cost += 2 + cur_delay;
                    wb_cnt++;
                    cur_idx = (exp_q.size() > 0) ? exp_q[0] : -1;
                end
                checks++;
                if (cur_idx < 0 || wb_index !== S'(cur_idx)) begin
                    errors++;
                    $display("FAIL %s wb_index: got %0d expected %0d (cycle %0d)", tag, wb_index, cur_idx, cyc);
                end
                if (waited >= cur_delay) begin
                    wb_ack = 1'b1;
                    if (exp_q.size() > 0) begin
                        idx = exp_q.pop_front();
                        model[idx] = 1'b0;
                        if (idx == set_on_ack) begin
                            mark_dirty = 1'b1;
                            mark_index = S'(idx);
                            model[idx] = 1'b1;
                        end
                    end
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
            exp_busy = (done_cyc < 0 || cyc == done_cyc);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy: got %b expected %b (cycle %0d)", tag, busy, exp_busy, cyc);
            end
            step();
            cyc++;
        end
        wb_ack = 1'b0;
        mark_dirty = 1'b0;
        flush_req = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s timeout: flush_done never seen, expected at cycle %0d", tag, 1 + (N - n_dirty) + cost);
        end else if (done_cyc != 1 + (N - n_dirty) + cost) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, 1 + (N - n_dirty) + cost);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt);
        end
        checks++;
        if (wb_cnt != n_dirty || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s wb_count: got %0d expected %0d", tag, wb_cnt, n_dirty);
        end
        for (int i = 0; i < N; i++) begin
            query_index = S'(i);
            #1;
            checks++;
            if (query_dirty !== model[i]) begin
                errors++;
                $display("FAIL %s dirty[%0d] after flush: got %b expected %b", tag, i, query_dirty, model[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || wb_req !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b wb_req=%b flush_done=%b expected 0 0 0", busy, wb_req, flush_done);
        end
        do_reset();
        for (int i = 0; i < N; i++) begin
            query_index = S'(i);
            #1;
            checks++;
            if (query_dirty !== 1'b0) begin
                errors++;
                $display("FAIL reset dirty[%0d]: got %b expected 0", i, query_dirty);
            end
        end
    endtask

    task automatic test_mark_query();
        mark(2);
        query_index = 3'd2;
        #1;
        checks++;
        if (query_dirty !== model[2]) begin
            errors++;
            $display("FAIL mark_query idx2: got %b expected %b", query_dirty, model[2]);
        end
        query_index = 3'd3;
        #1;
        checks++;
        if (query_dirty !== model[3]) begin
            errors++;
            $display("FAIL mark_query idx3: got %b expected %b", query_dirty, model[3]);
        end
    endtask

    task automatic test_flush_two();
        do_reset();
        mark(1);
        mark(6);
        run_flush("flush_two", 2, -1, -1);
    endtask

    task automatic test_clean_flush();
        do_reset();
        run_flush("clean_flush", 2, -1, -1);
    endtask

    task automatic test_set_wins();
        do_reset();
        mark(4);
        run_flush("set_wins", 1, 4, -1);
    endtask

    task automatic test_flush_while_busy();
        mark(3);
        run_flush("busy_pulse", 1, -1, 2);
    endtask

    task automatic test_reset_mid_flush();
        int n;
        int cnt;
        do_reset();
        mark(5);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        n = 0;
        while (n < 40 && !(wb_req === 1'b1 && wb_index === 3'd5)) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL reset_mid wait: wb_req for set 5 not seen, got wb_req=%b wb_index=%0d", wb_req, wb_index);
        end
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        #1;
        checks++;
        if (wb_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: wb_req=%b busy=%b expected 0 0", wb_req, busy);
        end
        for (int i = 0; i < N; i++) begin
            query_index = S'(i);
            #1;
            checks++;
            if (query_dirty !== model[i]) begin
                errors++;
                $display("FAIL reset_mid dirty[%0d]: got %b expected %b", i, query_dirty, model[i]);
            end
        end
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (flush_done !== 1'b0 || wb_req !== 1'b0) cnt++;
            step();
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL reset_mid no_done: %0d cycles with flush_done/wb_req high, expected 0", cnt);
        end
    endtask

    task automatic test_random();
        int k;
        for (int it = 0; it < 8; it++) begin
            k = int'($urandom_range(0, 4));
            for (int j = 0; j < k; j++) mark(int'($urandom_range(0, N - 1)));
            run_flush("random", -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_mark_query();
        test_flush_two();
        test_clean_flush();
        test_set_wins();
        test_flush_while_busy();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
